change_dispenser: RTL and testbench



---
 rtl/vend_pkg.sv | 23 ++
 rtl/coin_select.sv | 38 +++
 rtl/change_dispenser.sv | 153 +++++++++++++++
 tb/tb_change_dispenser.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine coin path: coin encodings,
// default coin values and the change dispenser state encodings.
package vend_pkg;

    // Default coin values in cents (penny is always 1)
    localparam int V_Q_DEF = 25;
    localparam int V_D_DEF = 10;
    localparam int V_N_DEF = 5;

    // Coin-type encodings presented to the hopper
    localparam logic [1:0] COIN_Q = 2'b00;
    localparam logic [1:0] COIN_D = 2'b01;
    localparam logic [1:0] COIN_N = 2'b10;
    localparam logic [1:0] COIN_P = 2'b11;

    // change_dispenser states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CALC    = 3'd1;
    localparam logic [2:0] ST_SELECT  = 3'd2;
    localparam logic [2:0] ST_PRESENT = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

endpackage

// File: rtl/coin_select.sv
// Combinational largest-coin picker: given a remaining amount, returns the
// largest coin not exceeding it, plus that coin's value. A zero amount yields
// a penny; callers must treat zero separately.
module coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 8,
    parameter int V_Q   = V_Q_DEF,
    parameter int V_D   = V_D_DEF,
    parameter int V_N   = V_N_DEF
) (
    input  logic [AMT_W-1:0] remaining_i,
    output logic [1:0]       coin_type_o,
    output logic [AMT_W-1:0] coin_value_o
);

    localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(V_Q);
    localparam logic [AMT_W-1:0] VAL_D = AMT_W'(V_D);
    localparam logic [AMT_W-1:0] VAL_N = AMT_W'(V_N);
    localparam logic [AMT_W-1:0] VAL_P = AMT_W'(1);

    // Greedy priority: quarter, dime, nickel, penny
    always_comb begin
        coin_type_o  = COIN_P;
        coin_value_o = VAL_P;
        if (remaining_i >= VAL_Q) begin
            coin_type_o  = COIN_Q;
            coin_value_o = VAL_Q;
        end else if (remaining_i >= VAL_D) begin
            coin_type_o  = COIN_D;
            coin_value_o = VAL_D;
        end else if (remaining_i >= VAL_N) begin
            coin_type_o  = COIN_N;
            coin_value_o = VAL_N;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: computes credit - price and pays the difference out one
// coin per valid/ack handshake, largest coin first. All outputs registered.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W = 8,
    parameter int V_Q   = V_Q_DEF,
    parameter int V_D   = V_D_DEF,
    parameter int V_N   = V_N_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] credit,
    input  logic [AMT_W-1:0] price,
    input  logic             coin_ack,
    output logic             busy,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    output logic [AMT_W-1:0] coin_count,
    output logic             done,
    output logic             err_short
);

    logic [2:0]       state_q,  state_d;
    logic [AMT_W-1:0] credit_q, credit_d;
    logic [AMT_W-1:0] price_q,  price_d;
    logic [AMT_W-1:0] rem_q,    rem_d;
    logic             short_q,  short_d;
    logic             busy_q,   busy_d;
    logic             valid_q,  valid_d;
    logic [1:0]       type_q,   type_d;
    logic [AMT_W-1:0] count_q,  count_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;

    logic [AMT_W:0]   diff;
    logic [1:0]       sel_type;
    logic [AMT_W-1:0] sel_value;

    coin_select #(
        .AMT_W (AMT_W),
        .V_Q   (V_Q),
        .V_D   (V_D),
        .V_N   (V_N)
    ) u_coin_select (
        .remaining_i  (rem_q),
        .coin_type_o  (sel_type),
        .coin_value_o (sel_value)
    );

    // Next-state and output-register logic; done/err_short/busy are derived
    // from the next state so they appear in the same cycle as that state.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        price_d  = price_q;
        rem_d    = rem_q;
        short_d  = short_q;
        valid_d  = valid_q;
        type_d   = type_q;
        count_d  = count_q;
        diff     = {1'b0, credit_q} - {1'b0, price_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    credit_d = credit;
                    price_d  = price;
                    count_d  = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                if (diff[AMT_W]) begin
                    rem_d   = '0;
                    short_d = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    rem_d   = diff[AMT_W-1:0];
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (rem_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    type_d  = sel_type;
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // rem_q is unchanged since SELECT, so sel_value matches the presented coin
                if (coin_ack) begin
                    rem_d   = rem_q - sel_value;
                    count_d = count_q + AMT_W'(1);
                    valid_d = 1'b0;
                    state_d = ST_SELECT;
                end
            end
            ST_FINISH: begin
                short_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
        err_d  = (state_d == ST_FINISH) && short_d;
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            price_q  <= '0;
            rem_q    <= '0;
            short_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            type_q   <= COIN_Q;
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            price_q  <= price_d;
            rem_q    <= rem_d;
            short_q  <= short_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            type_q   <= type_d;
            count_q  <= count_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy       = busy_q;
    assign coin_valid = valid_q;
    assign coin_type  = type_q;
    assign coin_count = count_q;
    assign done       = done_q;
    assign err_short  = err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser. The driver walks each transaction
// along the timeline the block must follow (latencies, one-cycle gaps,
// ack-paced coins) and publishes the expected outputs for every cycle; the
// coin sequence comes from plain greedy arithmetic on the change amount.
module tb_change_dispenser;

    localparam int AMT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [AMT_W-1:0] credit;
    logic [AMT_W-1:0] price;
    logic             coin_ack;
    logic             busy;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic [AMT_W-1:0] coin_count;
    logic             done;
    logic             err_short;

    int checks   = 0;
    int failures = 0;

    // Expected outputs for the current cycle
    bit       chk_en = 0;
    bit       e_busy, e_valid, e_done, e_err;
    bit [1:0] e_type;
    int       e_count;
    int       prev_count = 0;

    logic [1:0] coins[$];

    change_dispenser #(
        .AMT_W (AMT_W),
        .V_Q   (25),
        .V_D   (10),
        .V_N   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .credit     (credit),
        .price      (price),
        .coin_ack   (coin_ack),
        .busy       (busy),
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .coin_count (coin_count),
        .done       (done),
        .err_short  (err_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Greedy change from plain arithmetic
    task automatic build_coins(input int ch);
        coins.delete();
        for (int i = 0; i < ch / 25; i++) coins.push_back(2'b00);
        ch = ch % 25;
        for (int i = 0; i < ch / 10; i++) coins.push_back(2'b01);
        ch = ch % 10;
        for (int i = 0; i < ch / 5; i++) coins.push_back(2'b10);
        ch = ch % 5;
        for (int i = 0; i < ch; i++) coins.push_back(2'b11);
    endtask

    // Per-cycle comparison against the published expectations
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("busy", int'(busy), int'(e_busy));
            chk("coin_valid", int'(coin_valid), int'(e_valid));
            chk("coin_count", int'(coin_count), e_count);
            chk("done", int'(done), int'(e_done));
            chk("err_short", int'(err_short), int'(e_err));
            if (e_valid) chk("coin_type", int'(coin_type), int'(e_type));
        end
    end

    // Drive one cycle of inputs and the outputs expected during that cycle
    task automatic cyc(input bit s, input bit a, input bit eb, input bit ev,
                       input bit [1:0] et, input int ec, input bit ed, input bit ee);
        start    = s;
        coin_ack = a;
        e_busy   = eb;
        e_valid  = ev;
        e_type   = et;
        e_count  = ec;
        e_done   = ed;
        e_err    = ee;
        chk_en   = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic bit rnd_bit();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // One full transaction; ack delay per coin in [mind, maxd] cycles of valid
    task automatic run_txn(input int cr, input int pr, input int mind, input int maxd);
        int ch;
        int n;
        int d;
        ch = cr - pr;
        credit = AMT_W'(cr);
        price  = AMT_W'(pr);
        cyc(1, rnd_bit(), 0, 0, 2'b00, prev_count, 0, 0);
        // Inputs are only sampled on the start cycle
        credit = AMT_W'($urandom);
        price  = AMT_W'($urandom);
        cyc(rnd_bit(), rnd_bit(), 1, 0, 2'b00, 0, 0, 0);
        if (ch < 0) begin
            cyc(rnd_bit(), rnd_bit(), 1, 0, 2'b00, 0, 1, 1);
            prev_count = 0;
        end else begin
            build_coins(ch);
            n = coins.size();
            cyc(rnd_bit(), rnd_bit(), 1, 0, 2'b00, 0, 0, 0);
            for (int i = 0; i < n; i++) begin
                d = $urandom_range(mind, maxd);
                for (int k = 0; k <= d; k++)
                    cyc(rnd_bit(), (k == d), 1, 1, coins[i], i, 0, 0);
                cyc(rnd_bit(), rnd_bit(), 1, 0, 2'b00, i + 1, 0, 0);
            end
            cyc(rnd_bit(), rnd_bit(), 1, 0, 2'b00, n, 1, 0);
            prev_count = n;
        end
        cyc(0, rnd_bit(), 0, 0, 2'b00, prev_count, 0, 0);
    endtask

    initial begin
        int cr;
        int pr;
        logic [17:0] packed_types;

        rst_n    = 1'b0;
        start    = 1'b0;
        credit   = '0;
        price    = '0;
        coin_ack = 1'b0;
        #23;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(coin_valid), 0);
        chk("rst_type", int'(coin_type), 0);
        chk("rst_count", int'(coin_count), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_short), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pin the greedy model against hand-computed sequences
        build_coins(99);
        chk("model99_len", coins.size(), 9);
        packed_types = '0;
        foreach (coins[i]) packed_types = {packed_types[15:0], coins[i]};
        chk("model99_seq", int'(packed_types), int'(18'b00_00_00_01_01_11_11_11_11));
        build_coins(40);
        chk("model40_len", coins.size(), 3);

        run_txn(100, 60, 1, 1);
        chk("count_100_60", int'(coin_count), 3);
        run_txn(99, 0, 0, 2);
        chk("count_99_0", int'(coin_count), 9);
        run_txn(50, 50, 0, 0);
        chk("count_50_50", int'(coin_count), 0);
        run_txn(30, 75, 0, 0);
        chk("busy_after_short", int'(busy), 0);
        run_txn(35, 0, 5, 5);
        chk("count_35_0", int'(coin_count), 2);
        run_txn(255, 0, 0, 1);
        chk("count_255_0", int'(coin_count), 11);
        run_txn(0, 255, 0, 0);

        // Reset while a coin is being presented
        credit = 8'd35;
        price  = 8'd0;
        cyc(1, 0, 0, 0, 2'b00, prev_count, 0, 0);
        cyc(0, 0, 1, 0, 2'b00, 0, 0, 0);
        cyc(0, 0, 1, 0, 2'b00, 0, 0, 0);
        cyc(0, 0, 1, 1, 2'b00, 0, 0, 0);
        chk_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(coin_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_count", int'(coin_count), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        prev_count = 0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0);
        run_txn(35, 0, 0, 2);

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            cr = $urandom_range(0, 255);
            pr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, cr);
            run_txn(cr, pr, 0, 3);
            for (int k = 0; k < $urandom_range(0, 2); k++)
                cyc(0, rnd_bit(), 0, 0, 2'b00, prev_count, 0, 0);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
